// File: rtl/seq_malu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seq_malu                                                      |
// | Purpose  : Multi-cycle modular ALU, one operation in flight.             |
// |            op 00: a^b mod m    op 01: (a+b) mod m                        |
// |            op 10: a*b mod m    op 11: a mod b                            |
// |            Shift-subtract reduction, interleaved modular multiply.       |
// | Ports    : clk, rst_n (sync, active-low)                                 |
// |            in_valid/in_ready, op[1:0], a, b, m      command side         |
// |            out_valid/out_ready, result, err         result side          |
// |            busy: accept until result handshake                           |
// | Config   : MALU_EXP_SKIP_LZ_EN - mExp skips leading zero exponent bits   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module seq_malu #(
    parameter int WIDTH = 128,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic             busy
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_red_a = 3'd1;
    localparam logic [2:0] c_st_red_b = 3'd2;
    localparam logic [2:0] c_st_add   = 3'd3;
    localparam logic [2:0] c_st_mul   = 3'd4;
    localparam logic [2:0] c_st_sqr   = 3'd5;
    localparam logic [2:0] c_st_emul  = 3'd6;
    localparam logic [2:0] c_st_done  = 3'd7;

    localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_width = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_b;       // raw b: multiplier for mMul, exponent for mExp
    logic [WIDTH-1:0] r_m;       // active modulus (b for op 11)
    logic [WIDTH-1:0] r_ra;      // a reduced mod r_m
    logic [WIDTH-1:0] r_mq;      // bit source scanned MSB first (dividend / multiplier)
    logic [WIDTH-1:0] r_md;      // multiplicand; holds reduced b for mAdd
    logic [WIDTH-1:0] r_p;       // partial remainder / partial product, always < r_m
    logic [WIDTH-1:0] r_e;       // exponent bits still to scan, MSB first
    logic [WIDTH-1:0] r_result;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_ecnt;    // exponent bits remaining including the current one

    logic [WIDTH-1:0] w_in_mod;
    logic             w_in_zero;
    logic             w_last;
    logic [WIDTH-1:0] w_one;
    logic [WIDTH:0]   w_m_ext;
    logic [WIDTH:0]   w_red_t;
    logic [WIDTH-1:0] w_red_n;
    logic [WIDTH:0]   w_dbl_t;
    logic [WIDTH-1:0] w_dbl_n;
    logic [WIDTH:0]   w_sum_t;
    logic [WIDTH-1:0] w_sum_n;
    logic [WIDTH-1:0] w_mul_n;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH:0]   w_add_t;
    logic [WIDTH-1:0] w_add_n;
    logic [CNT_W-1:0] w_exp_len;
    logic [WIDTH-1:0] w_exp_bits;

    assign w_in_mod  = (op == 2'b11) ? b : m;
    assign w_in_zero = (w_in_mod == '0);
    assign w_last    = (r_cnt == c_cnt_last);
    // Starting value of the exponent accumulator: 1 mod m.
    assign w_one     = (r_m == WIDTH'(1)) ? '0 : WIDTH'(1);
    assign w_m_ext   = {1'b0, r_m};

    // Restoring division step: bring in the next dividend bit, subtract once.
    assign w_red_t = {r_p, r_mq[WIDTH-1]};
    assign w_red_n = (w_red_t >= w_m_ext) ? WIDTH'(w_red_t - w_m_ext) : w_red_t[WIDTH-1:0];

    // Interleaved multiply step: p = 2p mod m, then conditionally (p + md) mod m.
    // Both sums stay below 2m, so a single conditional subtract suffices.
    assign w_dbl_t = {r_p, 1'b0};
    assign w_dbl_n = (w_dbl_t >= w_m_ext) ? WIDTH'(w_dbl_t - w_m_ext) : w_dbl_t[WIDTH-1:0];
    assign w_sum_t = {1'b0, w_dbl_n} + {1'b0, r_md};
    assign w_sum_n = (w_sum_t >= w_m_ext) ? WIDTH'(w_sum_t - w_m_ext) : w_sum_t[WIDTH-1:0];
    assign w_mul_n = r_mq[WIDTH-1] ? w_sum_n : w_dbl_n;

    assign w_step = ((r_state == c_st_red_a) || (r_state == c_st_red_b)) ? w_red_n : w_mul_n;

    assign w_add_t = {1'b0, r_ra} + {1'b0, r_md};
    assign w_add_n = (w_add_t >= w_m_ext) ? WIDTH'(w_add_t - w_m_ext) : w_add_t[WIDTH-1:0];

    // Exponent scan window: number of bits to process and the bits left-aligned.
    always_comb begin
`ifdef MALU_EXP_SKIP_LZ_EN
        w_exp_len = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_b[i]) begin
                w_exp_len = CNT_W'(i + 1);
            end
        end
        w_exp_bits = r_b << (c_cnt_width - w_exp_len);
`else
        w_exp_len  = c_cnt_width;
        w_exp_bits = r_b;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            c_st_idle: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_nxt = w_in_zero ? c_st_done : c_st_red_a;
                end
            end
            c_st_red_a: begin
                if (w_last) begin
                    case (r_op)
                        2'b11:   w_state_nxt = c_st_done;
                        2'b01:   w_state_nxt = c_st_red_b;
                        2'b10:   w_state_nxt = c_st_mul;
                        default: w_state_nxt = (w_exp_len == '0) ? c_st_done : c_st_sqr;
                    endcase
                end
            end
            c_st_red_b: begin
                if (w_last) begin
                    w_state_nxt = c_st_add;
                end
            end
            c_st_add: begin
                w_state_nxt = c_st_done;
            end
            c_st_mul: begin
                if (w_last) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_sqr: begin
                if (w_last) begin
                    if (r_e[WIDTH-1]) begin
                        w_state_nxt = c_st_emul;
                    end else if (r_ecnt == c_cnt_one) begin
                        w_state_nxt = c_st_done;
                    end else begin
                        w_state_nxt = c_st_sqr;
                    end
                end
            end
            c_st_emul: begin
                if (w_last) begin
                    w_state_nxt = (r_ecnt == c_cnt_one) ? c_st_done : c_st_sqr;
                end
            end
            c_st_done: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_b      <= '0;
            r_m      <= '0;
            r_ra     <= '0;
            r_mq     <= '0;
            r_md     <= '0;
            r_p      <= '0;
            r_e      <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
            r_ecnt   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_op  <= op;
                        r_b   <= b;
                        r_m   <= w_in_mod;
                        r_mq  <= a;
                        r_p   <= '0;
                        r_cnt <= '0;
                        r_err <= w_in_zero;
                        if (w_in_zero) begin
                            r_result <= '0;
                        end
                    end
                end
                c_st_add: begin
                    r_result <= w_add_n;
                end
                c_st_done: begin
                end
                default: begin
                    // All WIDTH-cycle phases share one step datapath.
                    r_p   <= w_step;
                    r_mq  <= r_mq << 1;
                    r_cnt <= w_last ? '0 : r_cnt + c_cnt_one;
                    if (w_last) begin
                        case (r_state)
                            c_st_red_a: begin
                                r_ra <= w_step;
                                r_p  <= '0;
                                case (r_op)
                                    2'b11: r_result <= w_step;
                                    2'b01: r_mq <= r_b;
                                    2'b10: begin
                                        r_mq <= r_b;
                                        r_md <= w_step;
                                    end
                                    default: begin
                                        r_e    <= w_exp_bits;
                                        r_ecnt <= w_exp_len;
                                        r_mq   <= w_one;
                                        r_md   <= w_one;
                                        if (w_exp_len == '0) begin
                                            r_result <= w_one;
                                        end
                                    end
                                endcase
                            end
                            c_st_red_b: begin
                                r_md <= w_step;
                            end
                            c_st_mul: begin
                                r_result <= w_step;
                            end
                            c_st_sqr: begin
                                r_p  <= '0;
                                r_mq <= w_step;
                                if (r_e[WIDTH-1]) begin
                                    // Exponent bit set: multiply the square by reduced a.
                                    r_md <= r_ra;
                                end else begin
                                    r_md   <= w_step;
                                    r_e    <= r_e << 1;
                                    r_ecnt <= r_ecnt - c_cnt_one;
                                    if (r_ecnt == c_cnt_one) begin
                                        r_result <= w_step;
                                    end
                                end
                            end
                            default: begin
                                r_p    <= '0;
                                r_mq   <= w_step;
                                r_md   <= w_step;
                                r_e    <= r_e << 1;
                                r_ecnt <= r_ecnt - c_cnt_one;
                                if (r_ecnt == c_cnt_one) begin
                                    r_result <= w_step;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign result = r_result;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seq_malu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seq_malu                                                   |
// | Purpose  : Self-checking bench for seq_malu at WIDTH=8. Expected results |
// |            and latencies come from plain integer arithmetic.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_seq_malu;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       op = '0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [WIDTH-1:0] m = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] result;
    logic             err;
    logic             busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_malu #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .m         (m),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: result, err and latency straight from the arithmetic definition.
    function automatic void model(input int unsigned f_op, input int unsigned fa,
                                  input int unsigned fb, input int unsigned fm,
                                  output int unsigned res, output int unsigned e,
                                  output int unsigned lat);
        int unsigned md;
        int unsigned r;
        int unsigned nbits;
        int unsigned pop;
        md = (f_op == 3) ? fb : fm;
        res = 0;
        e = 0;
        lat = 1;
        if (md == 0) begin
            e = 1;
        end else if (f_op == 3) begin
            res = fa % fb;
            lat = WIDTH + 1;
        end else if (f_op == 1) begin
            res = (fa + fb) % fm;
            lat = 2 * WIDTH + 2;
        end else if (f_op == 2) begin
            res = (fa * fb) % fm;
            lat = 2 * WIDTH + 1;
        end else begin
            r = 1 % fm;
            for (int k = 0; k < int'(fb); k++) r = (r * fa) % fm;
            res = r;
            pop = 0;
            for (int k = 0; k < WIDTH; k++) pop += (fb >> k) & 1;
            nbits = WIDTH;
`ifdef MALU_EXP_SKIP_LZ_EN
            nbits = 0;
            for (int k = 0; k < WIDTH; k++) if (((fb >> k) & 1) == 1) nbits = k + 1;
`endif
            lat = WIDTH + nbits * WIDTH + pop * WIDTH + 1;
        end
    endfunction

    task automatic run_cmd(input int unsigned t_op, input int unsigned ta, input int unsigned tb_v,
                           input int unsigned tm, input int hold);
        int unsigned e_res;
        int unsigned e_err;
        int unsigned e_lat;
        int          lat;
        logic [WIDTH-1:0] held;
        model(t_op, ta, tb_v, tm, e_res, e_err, e_lat);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        op       = 2'(t_op);
        a        = WIDTH'(ta);
        b        = WIDTH'(tb_v);
        m        = WIDTH'(tm);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op = 2'($urandom);
        a  = WIDTH'($urandom);
        b  = WIDTH'($urandom);
        m  = WIDTH'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), e_lat);
        check("result", 32'(result), e_res);
        check("err", 32'(err), e_err);
        held = result;
        repeat (hold) begin
            @(negedge clk);
            check("hold_result", 32'(result), 32'(held));
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_out_valid", 32'(out_valid), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int unsigned r_op;
        int unsigned r_a;
        int unsigned r_b;
        int unsigned r_m;
        bit seen;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Directed cases
        run_cmd(3, 255, 16, 0, 0);
        run_cmd(1, 250, 250, 251, 0);
        run_cmd(2, 200, 150, 37, 5);
        run_cmd(0, 3, 200, 50, 0);
        run_cmd(0, 2, 5, 7, 0);
        run_cmd(2, 77, 5, 0, 2);
        run_cmd(0, 9, 0, 1, 0);
        run_cmd(3, 123, 0, 9, 0);
        run_cmd(0, 200, 0, 13, 0);
        run_cmd(2, 0, 123, 97, 0);
        run_cmd(1, 255, 255, 255, 0);
        run_cmd(0, 250, 255, 251, 1);

        // Randomized commands
        for (int n = 0; n < 25; n++) begin
            r_op = $urandom_range(0, 3);
            r_a  = $urandom_range(0, 255);
            r_b  = $urandom_range(0, 255);
            case ($urandom_range(0, 7))
                0:       r_m = 0;
                1:       r_m = 1;
                default: r_m = $urandom_range(2, 255);
            endcase
            if ($urandom_range(0, 7) == 0) r_a = 0;
            if (r_op == 3 && $urandom_range(0, 7) == 0) r_b = 0;
            run_cmd(r_op, r_a, r_b, r_m, int'($urandom_range(0, 2)));
        end

        // Reset in the middle of an mExp aborts it
        @(negedge clk);
        op = 2'd0; a = 8'd3; b = 8'd200; m = 8'd50; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("abort_rst_in_ready", 32'(in_ready), 32'd1);
        check("abort_rst_busy", 32'(busy), 32'd0);
        check("abort_rst_result", 32'(result), 32'd0);
        check("abort_rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_in_ready_after_release", 32'(in_ready), 32'd1);
        repeat (150) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("abort_no_out_valid", 32'(seen), 32'd0);
        run_cmd(2, 200, 150, 37, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
